// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the 8N1 UART transceiver.
// Optional even parity is enabled by defining UART_PARITY_EN.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int SAMPLE_MID = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Rounded clock divider for the 16x oversampling tick, never below 1.
  function automatic int calc_divisor(input int freq_hz, input int baud);
    int d;
    d = (freq_hz + 8 * baud) / (16 * baud);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider that emits a one-cycle tick every
// DIVISOR clocks; shared 16x oversampling enable for RX and TX.
module uart_baud_gen #(
  parameter int DIVISOR = 27
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Count 0..DIVISOR-1 and register a tick pulse on each wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex 8N1 UART, LSB first, idle-high line,
// 16x oversampled receiver and transmitter sharing one baud tick.
// Define UART_PARITY_EN to add an even-parity bit (11-bit frame) on both
// directions; rx_error then also flags parity mismatches.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int freq_hz = 50000000,
  parameter int baud    = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_error,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy
);

  localparam int         DIVISOR   = calc_divisor(freq_hz, baud);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(SAMPLE_MID - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  logic w_tick;
  logic w_rxd;

  uart_baud_gen #(
    .DIVISOR(DIVISOR)
  ) u_baud_gen (
    .i_clk  (clk),
    .i_rst_n(reset),
    .o_tick (w_tick)
  );

  // ---------------------------------------------------------------- RX
  logic       r_rxd_meta;
  logic       r_rxd_sync;
  rx_state_t  r_rx_state;
  logic [3:0] r_rx_tick_cnt;
  logic [2:0] r_rx_bit_cnt;
  logic [7:0] r_rx_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_avail;
  logic       r_rx_error;
  logic       r_rx_wait_high;
`ifdef UART_PARITY_EN
  logic       r_rx_par_err;
`endif

  // Two-flop synchronizer for the asynchronous serial input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= uart_rxd;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  assign w_rxd = r_rxd_sync;

  // Receive FSM: start validation at mid-bit, centre sampling, output hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_state     <= RX_IDLE;
      r_rx_tick_cnt  <= '0;
      r_rx_bit_cnt   <= '0;
      r_rx_data      <= '0;
      r_rx_avail     <= 1'b0;
      r_rx_error     <= 1'b0;
      r_rx_wait_high <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par_err   <= 1'b0;
`endif
    end else begin
      // Acknowledge first so a completing byte in the same cycle wins.
      if (rx_ack) r_rx_avail <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_tick_cnt <= '0;
          // After a zero stop bit, wait for the line to go high before
          // looking for a new start edge.
          if (r_rx_wait_high) begin
            if (w_rxd) r_rx_wait_high <= 1'b0;
          end else if (!w_rxd) begin
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (w_tick) begin
            if (r_rx_tick_cnt == MID_TICK) begin
              r_rx_tick_cnt <= '0;
              r_rx_bit_cnt  <= '0;
              r_rx_state    <= w_rxd ? RX_IDLE : RX_DATA;
            end else begin
              r_rx_tick_cnt <= r_rx_tick_cnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            r_rx_tick_cnt <= r_rx_tick_cnt + 4'd1;
            if (r_rx_tick_cnt == LAST_TICK) begin
              r_rx_shift   <= {w_rxd, r_rx_shift[7:1]};
              r_rx_bit_cnt <= r_rx_bit_cnt + 3'd1;
              if (r_rx_bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
                r_rx_state <= RX_PARITY;
`else
                r_rx_state <= RX_STOP;
`endif
              end
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (w_tick) begin
            r_rx_tick_cnt <= r_rx_tick_cnt + 4'd1;
            if (r_rx_tick_cnt == LAST_TICK) begin
              r_rx_par_err <= w_rxd ^ (^r_rx_shift);
              r_rx_state   <= RX_STOP;
            end
          end
        end
`endif
        RX_STOP: begin
          if (w_tick) begin
            r_rx_tick_cnt <= r_rx_tick_cnt + 4'd1;
            if (r_rx_tick_cnt == LAST_TICK) begin
              r_rx_data      <= r_rx_shift;
              r_rx_avail     <= 1'b1;
`ifdef UART_PARITY_EN
              r_rx_error     <= ~w_rxd | r_rx_par_err;
`else
              r_rx_error     <= ~w_rxd;
`endif
              r_rx_wait_high <= ~w_rxd;
              r_rx_state     <= RX_IDLE;
            end
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_avail = r_rx_avail;
  assign rx_error = r_rx_error;

  // ---------------------------------------------------------------- TX
  tx_state_t  r_tx_state;
  logic [3:0] r_tx_tick_cnt;
  logic [2:0] r_tx_bit_cnt;
  logic [7:0] r_tx_shift;
  logic       r_txd;
  logic       r_tx_busy;
`ifdef UART_PARITY_EN
  logic       r_tx_par;
`endif

  // Transmit FSM: each bit held for 16 ticks, line output registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_state    <= TX_IDLE;
      r_tx_tick_cnt <= '0;
      r_tx_bit_cnt  <= '0;
      r_txd         <= 1'b1;
      r_tx_busy     <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_txd         <= 1'b1;
          r_tx_tick_cnt <= '0;
          r_tx_bit_cnt  <= '0;
          if (tx_wr) begin
            r_tx_shift <= tx_data;
`ifdef UART_PARITY_EN
            r_tx_par   <= ^tx_data;
`endif
            r_txd      <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tick) begin
            r_tx_tick_cnt <= r_tx_tick_cnt + 4'd1;
            if (r_tx_tick_cnt == LAST_TICK) begin
              r_txd      <= r_tx_shift[0];
              r_tx_state <= TX_DATA;
            end
          end
        end
        TX_DATA: begin
          if (w_tick) begin
            r_tx_tick_cnt <= r_tx_tick_cnt + 4'd1;
            if (r_tx_tick_cnt == LAST_TICK) begin
              r_tx_bit_cnt <= r_tx_bit_cnt + 3'd1;
              if (r_tx_bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
                r_txd      <= r_tx_par;
                r_tx_state <= TX_PARITY;
`else
                r_txd      <= 1'b1;
                r_tx_state <= TX_STOP;
`endif
              end else begin
                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                r_txd      <= r_tx_shift[1];
              end
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (w_tick) begin
            r_tx_tick_cnt <= r_tx_tick_cnt + 4'd1;
            if (r_tx_tick_cnt == LAST_TICK) begin
              r_txd      <= 1'b1;
              r_tx_state <= TX_STOP;
            end
          end
        end
`endif
        TX_STOP: begin
          if (w_tick) begin
            r_tx_tick_cnt <= r_tx_tick_cnt + 4'd1;
            if (r_tx_tick_cnt == LAST_TICK) begin
              r_tx_busy  <= 1'b0;
              r_tx_state <= TX_IDLE;
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign uart_txd = r_txd;
  assign tx_busy  = r_tx_busy;

endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: randomized self-checking bench for uart_transceiver.
// Expected line waveforms and received bytes come from a frame model
// (start bit, data LSB first, optional even parity, stop bit).
module tb_uart_transceiver;

  localparam int DIV     = 27;
  localparam int BIT_CYC = 16 * DIV;
  localparam int HALF    = BIT_CYC / 2;
`ifdef UART_PARITY_EN
  localparam int NBITS   = 11;
`else
  localparam int NBITS   = 10;
`endif

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       rxd_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_ack  = 1'b0;
  logic       tx_wr   = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       uart_rxd;
  logic       uart_txd;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_error;
  logic       tx_busy;

  int checks = 0;
  int errors = 0;

  assign uart_rxd = loop_en ? uart_txd : rxd_drv;

  always #5 clk = ~clk;

  uart_transceiver #(
    .freq_hz(50000000),
    .baud   (115200)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .uart_rxd(uart_rxd),
    .uart_txd(uart_txd),
    .rx_data (rx_data),
    .rx_avail(rx_avail),
    .rx_error(rx_error),
    .rx_ack  (rx_ack),
    .tx_data (tx_data),
    .tx_wr   (tx_wr),
    .tx_busy (tx_busy)
  );

  // Reference frame: bit k of the serial frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int v;
    v = b;
    if (k == 0) return 1'b0;
    if (k <= 8) return 1'(((v >> (k - 1)) & 1));
    if (NBITS == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_wr(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  // Drive one frame onto rxd with a chosen stop-bit level.
  task automatic send_serial(input logic [7:0] b, input logic stop_bit);
    for (int k = 0; k < NBITS; k++) begin
      rxd_drv = (k == NBITS - 1) ? stop_bit : frame_bit(b, k);
      wait_cycles(BIT_CYC);
    end
    rxd_drv = 1'b1;
  endtask

  // Check a TX frame already launched; optionally strobe a second write mid-frame.
  task automatic check_tx_frame(input logic [7:0] b, input logic inject, input logic [7:0] other);
    int n;
    int k;
    int busy_cyc;
    logic exp;
    n = 0;
    k = 0;
    busy_cyc = 0;
    while (uart_txd !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (uart_txd !== 1'b0) begin
      errors++;
      $display("FAIL tx_start_%02h: txd=%b required 0 within 64 cycles", b, uart_txd);
      return;
    end
    for (int c = 0; c < NBITS * BIT_CYC + 200; c++) begin
      if (k < NBITS && c == HALF + k * BIT_CYC) begin
        exp = frame_bit(b, k);
        checks++;
        if (uart_txd !== exp) begin
          errors++;
          $display("FAIL tx_bit%0d_%02h: got %b required %b", k, b, uart_txd, exp);
        end
        k++;
      end
      if (tx_busy === 1'b1) busy_cyc++;
      else if (k == NBITS) break;
      if (inject && c == 100) begin
        checks++;
        if (tx_busy !== 1'b1) begin
          errors++;
          $display("FAIL tx_busy_mid: got %b required 1", tx_busy);
        end
        tx_data = other;
        tx_wr   = 1'b1;
      end
      if (inject && c == 101) tx_wr = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (k != NBITS || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL tx_end_%02h: bits=%0d busy=%b required bits=%0d busy=0", b, k, tx_busy, NBITS);
    end
    checks++;
    if (busy_cyc < NBITS * BIT_CYC - DIV - 2 || busy_cyc > NBITS * BIT_CYC + 2) begin
      errors++;
      $display("FAIL tx_busy_len_%02h: got %0d required %0d..%0d", b, busy_cyc,
               NBITS * BIT_CYC - DIV - 2, NBITS * BIT_CYC + 2);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wait_cycles(4);
    checks++;
    if (uart_txd !== 1'b1) begin errors++; $display("FAIL rst_txd: got %b required 1", uart_txd); end
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", tx_busy); end
    checks++;
    if (rx_avail !== 1'b0) begin errors++; $display("FAIL rst_avail: got %b required 0", rx_avail); end
    checks++;
    if (rx_error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b required 0", rx_error); end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %02h required 00", rx_data); end
    reset = 1'b1;
    wait_cycles(3);
  endtask

  task automatic test_tx(input logic [7:0] b);
    pulse_wr(b);
    check_tx_frame(b, 1'b0, 8'h00);
    wait_cycles(20);
  endtask

  task automatic test_busy();
    pulse_wr(8'h22);
    check_tx_frame(8'h22, 1'b1, 8'h11);
    begin
      int lows;
      lows = 0;
      for (int c = 0; c < 1000; c++) begin
        if (uart_txd !== 1'b1 || tx_busy !== 1'b0) lows++;
        @(negedge clk);
      end
      checks++;
      if (lows != 0) begin
        errors++;
        $display("FAIL busy_drop: %0d cycles of activity after frame, required 0", lows);
      end
    end
  endtask

  task automatic test_loopback(input logic [7:0] b);
    int n;
    loop_en = 1'b1;
    pulse_wr(b);
    n = 0;
    while (rx_avail !== 1'b1 && n < 2 * NBITS * BIT_CYC) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rx_avail !== 1'b1) begin
      errors++;
      $display("FAIL loop_avail_%02h: got %b required 1", b, rx_avail);
    end
    checks++;
    if (rx_data !== b) begin errors++; $display("FAIL loop_data: got %02h required %02h", rx_data, b); end
    checks++;
    if (rx_error !== 1'b0) begin errors++; $display("FAIL loop_error: got %b required 0", rx_error); end
    pulse_ack();
    checks++;
    if (rx_avail !== 1'b0) begin errors++; $display("FAIL loop_ack: avail=%b required 0", rx_avail); end
    n = 0;
    while (tx_busy !== 1'b0 && n < 2 * BIT_CYC) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL loop_busy_end: got %b required 0", tx_busy); end
    wait_cycles(10);
    loop_en = 1'b0;
  endtask

  task automatic test_framing();
    send_serial(8'h55, 1'b0);
    // Hold the line low past the stop bit; it must not start a new frame.
    rxd_drv = 1'b0;
    wait_cycles(2 * BIT_CYC);
    rxd_drv = 1'b1;
    checks++;
    if (rx_avail !== 1'b1) begin errors++; $display("FAIL frm_avail: got %b required 1", rx_avail); end
    checks++;
    if (rx_error !== 1'b1) begin errors++; $display("FAIL frm_error: got %b required 1", rx_error); end
    checks++;
    if (rx_data !== 8'h55) begin errors++; $display("FAIL frm_data: got %02h required 55", rx_data); end
    pulse_ack();
    checks++;
    if (rx_avail !== 1'b0 || rx_error !== 1'b1) begin
      errors++;
      $display("FAIL frm_ack: avail=%b error=%b required avail=0 error=1", rx_avail, rx_error);
    end
    pulse_ack();
    checks++;
    if (rx_avail !== 1'b0 || rx_error !== 1'b1) begin
      errors++;
      $display("FAIL frm_ack_idle: avail=%b error=%b required avail=0 error=1", rx_avail, rx_error);
    end
    wait_cycles(5000);
    checks++;
    if (rx_avail !== 1'b0) begin errors++; $display("FAIL frm_retrigger: avail=%b required 0", rx_avail); end
  endtask

  task automatic test_glitch();
    rxd_drv = 1'b0;
    wait_cycles(3 * DIV);
    rxd_drv = 1'b1;
    wait_cycles(4500);
    checks++;
    if (rx_avail !== 1'b0) begin errors++; $display("FAIL glitch_avail: got %b required 0", rx_avail); end
  endtask

  task automatic test_overrun();
    send_serial(8'h01, 1'b1);
    checks++;
    if (rx_avail !== 1'b1 || rx_data !== 8'h01 || rx_error !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first: avail=%b data=%02h error=%b required 1/01/0", rx_avail, rx_data, rx_error);
    end
    wait_cycles(100);
    send_serial(8'h02, 1'b1);
    checks++;
    if (rx_avail !== 1'b1 || rx_data !== 8'h02 || rx_error !== 1'b0) begin
      errors++;
      $display("FAIL ovr_second: avail=%b data=%02h error=%b required 1/02/0", rx_avail, rx_data, rx_error);
    end
    pulse_ack();
    wait_cycles(20);
  endtask

  task automatic test_reset_midframe(input logic [7:0] b);
    pulse_wr(b);
    wait_cycles(1000);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst: txd=%b busy=%b required 1/0", uart_txd, tx_busy);
    end
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(10);
    checks++;
    if (uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: txd=%b busy=%b required 1/0", uart_txd, tx_busy);
    end
  endtask

  initial begin
    logic [7:0] r;
    test_reset();
    test_tx(8'hA5);
    for (int i = 0; i < 2; i++) begin
      r = 8'($urandom_range(0, 255));
      test_tx(r);
    end
    test_busy();
    test_loopback(8'h3C);
    for (int i = 0; i < 2; i++) begin
      r = 8'($urandom_range(0, 255));
      test_loopback(r);
    end
    test_framing();
    test_glitch();
    test_overrun();
    r = 8'($urandom_range(0, 255));
    test_reset_midframe(r);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- Full-duplex asynchronous serial transceiver: 8 data bits, no parity, 1 stop bit (8N1), LSB first; line idles high.
- Byte-wide parallel interface with a write strobe and busy flag on transmit, and an available/acknowledge handshake on receive.
- Sits between the system bus glue (UART register block) and the board RS-232 pins.
- All timing derives from a 16x-oversampling tick generated from the system clock.

Parameters:
- freq_hz, 50000000, system clock frequency in Hz.
- baud, 115200, line rate in bit/s.
- Derived constant DIVISOR = (freq_hz + 8*baud) / (16*baud), integer division (rounded); must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset asserted), sampled on rising clk.
- uart_rxd  in  1  serial input from line, asynchronous to clk.
- uart_txd  out  1  serial output to line.
- rx_data  out  8  last received byte.
- rx_avail  out  1  high while an unacknowledged byte is held in rx_data.
- rx_error  out  1  framing error flag for the byte in rx_data.
- rx_ack  in  1  single-cycle pulse; consumes the held byte.
- tx_data  in  8  byte to transmit, sampled when tx_wr is accepted.
- tx_wr  in  1  single-cycle transmit strobe.
- tx_busy  out  1  high while the transmitter is occupied.

Behaviour:
- Reset values: uart_txd=1, rx_data=0, rx_avail=0, rx_error=0, tx_busy=0. Both state machines go to IDLE and the tick counter clears. A reset mid-frame aborts the frame immediately, and the next cycle drives txd=1.
- Tick generator: counter 0..DIVISOR-1; emits a one-cycle enable `tick` on wrap. It is free-running and shared by RX and TX.
- RX input: 2-flop synchronizer on uart_rxd; all RX logic uses the synchronized value.
- RX FSM states:
  - IDLE: on synchronized rxd=0, go to START and clear the sample count.
  - START: at tick 8, re-check rxd. If 0, go to DATA; if 1, treat it as a glitch and return to IDLE.
  - DATA: sample one bit every 16 ticks, at bit centre, shifting LSB first; 8 bits.
  - STOP: sample at the stop-bit centre, then update the outputs:
    - rx_data is loaded;
    - rx_avail is set to 1;
    - rx_error is set to 1 if the stop bit = 0, otherwise 0;
    - return to IDLE. A zero stop bit with the line still low must not re-trigger until the line returns high.
- rx_ack:
  - rx_ack=1 clears rx_avail on the next edge; rx_error keeps its value until the next byte.
  - rx_ack while rx_avail=0 has no effect.
  - Overrun: a new byte completing while rx_avail=1 overwrites rx_data and rx_error, and rx_avail stays 1.
  - Completion and rx_ack in the same cycle: completion wins, so rx_avail=1.
- TX FSM states: IDLE, START, DATA, STOP.
  - tx_wr=1 with tx_busy=0 latches tx_data, and tx_busy=1 from the next edge.
  - Each bit lasts 16 ticks: start bit 0, then 8 data bits LSB first, then stop bit 1.
  - tx_busy falls in the cycle after the stop bit completes, and a new tx_wr is then accepted.
  - tx_wr while tx_busy=1 is ignored and the data is dropped.
  - Frame length is 160 ticks ± one tick of start-alignment jitter.

Optional Feature:
- Macro UART_PARITY_EN.
- When defined: an even-parity bit is inserted between the data bits and the stop bit on TX, and checked on RX. rx_error = framing error OR parity mismatch, and the frame is 11 bits.
- When undefined: plain 8N1 exactly as above, with no parity logic.

Decomposition:
- Package uart_pkg holds:
  - the RX and TX state enum typedefs;
  - constants OVERSAMPLE=16, DATA_BITS=8, SAMPLE_MID=8;
  - a function computing DIVISOR from freq_hz and baud.
- One sub-module, uart_baud_gen: parameterized divider producing the 16x tick enable.
- RX and TX stay inline in uart_transceiver.

Test Plan (bench at freq_hz=50000000, baud=115200 → DIVISOR=27):
- Reset: hold reset=0 for 4 cycles → txd=1, tx_busy=0, rx_avail=0, rx_error=0, rx_data=0.
- TX 0xA5: pulse tx_wr → txd shows 0, 1,0,1,0,0,1,0,1, then 1; each bit is 432 cycles; tx_busy is high about 4320 cycles, then low.
- Loopback: connect txd to rxd and send 0x3C → rx_avail=1 with rx_data=0x3C and rx_error=0; an rx_ack pulse drops rx_avail the next cycle.
- Framing: drive 0x55 with the stop bit forced to 0 → rx_avail=1, rx_error=1, rx_data=0x55.
- Glitch and busy:
  - a 3-tick low pulse on rxd → no rx_avail;
  - tx_wr with 0x11 while busy sending 0x22 → only 0x22 appears on the line.
- Overrun: send 0x01 then 0x02 without rx_ack → rx_data=0x02 and rx_avail stays 1.
